// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the pixel-render stage and its helpers.
package vga_pkg;
    localparam int H_VIS   = 640;
    localparam int V_VIS   = 480;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int SPR_W   = 32;
    localparam int SPR_H   = 32;
    localparam int BG_W    = H_VIS / 2;
    localparam int RGB_W   = 12;

    localparam logic [RGB_W-1:0] KEY = 12'hF0F;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef struct packed {
        logic visible;
        logic hit;
        logic hsync;
        logic vsync;
    } stage1_t;
endpackage

// File: rtl/vga_sprite_hit.sv
// Combinational sprite window test and sprite ROM address generation for one object.
module vga_sprite_hit
    import vga_pkg::*;
#(
    parameter int H_VIS = vga_pkg::H_VIS,
    parameter int V_VIS = vga_pkg::V_VIS,
    parameter int SPR_W = vga_pkg::SPR_W,
    parameter int SPR_H = vga_pkg::SPR_H
) (
    input  logic [9:0] col,
    input  logic [9:0] row,
    input  logic [9:0] lx,
    input  logic [9:0] ly,
    input  logic       len,
    output logic       visible,
    output logic       hit,
    output logic [9:0] spr_addr
);
    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_x;
    logic        in_y;

    // Bit 10 of the 11-bit difference is the sign: a negative offset is never inside the window.
    always_comb begin
        dx       = {1'b0, col} - {1'b0, lx};
        dy       = {1'b0, row} - {1'b0, ly};
        visible  = (col < 10'(H_VIS)) && (row < 10'(V_VIS));
        in_x     = !dx[10] && (dx[9:0] < 10'(SPR_W));
        in_y     = !dy[10] && (dy[9:0] < 10'(SPR_H));
        hit      = len && in_x && in_y && visible;
        spr_addr = '0;
        if (hit) begin
            spr_addr = 10'({dy[YB-1:0], dx[XB-1:0]});
        end
    end
endmodule

// File: rtl/vga_pixel_render.sv
// Composites a 2x-scaled background with one colour-keyed sprite; 2-cycle aligned RGB/sync out.
module vga_pixel_render
    import vga_pkg::*;
#(
    parameter int          H_VIS = vga_pkg::H_VIS,
    parameter int          V_VIS = vga_pkg::V_VIS,
    parameter int          SPR_W = vga_pkg::SPR_W,
    parameter int          SPR_H = vga_pkg::SPR_H,
    parameter int          BG_W  = vga_pkg::BG_W,
    parameter logic [11:0] KEY   = vga_pkg::KEY
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [9:0]  col,
    input  logic [9:0]  row,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  obj_x,
    input  logic [9:0]  obj_y,
    input  logic        obj_en,
    output logic [16:0] bg_addr,
    input  logic [11:0] bg_data,
    output logic [9:0]  spr_addr,
    input  logic [11:0] spr_data,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    logic [9:0] lx;
    logic [9:0] ly;
    logic       len;
    logic       visible;
    logic       hit;
    logic       latch_now;
    stage1_t    s1;
    rgb_t       pix;
    rgb_t       pix_next;

    assign bg_addr   = 17'(row[9:1]) * 17'(BG_W) + 17'(col[9:1]);
    assign latch_now = (col == 10'd0) && (row == 10'(V_VIS));

    vga_sprite_hit #(
        .H_VIS (H_VIS),
        .V_VIS (V_VIS),
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_hit (
        .col      (col),
        .row      (row),
        .lx       (lx),
        .ly       (ly),
        .len      (len),
        .visible  (visible),
        .hit      (hit),
        .spr_addr (spr_addr)
    );

    // Position is only sampled on the first blank line so a frame never shows a half-moved sprite.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            lx          <= '0;
            ly          <= '0;
            len         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= latch_now;
            if (latch_now) begin
                lx  <= obj_x;
                ly  <= obj_y;
                len <= obj_en;
            end
        end
    end

    // Stage 1 lines up visibility, hit and syncs with the ROM data that arrives one cycle later.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            s1 <= '{visible: 1'b0, hit: 1'b0, hsync: 1'b1, vsync: 1'b1};
        end else begin
            s1 <= '{visible: visible, hit: hit, hsync: hsync_in, vsync: vsync_in};
        end
    end

    always_comb begin
        pix_next = bg_data;
        if (!s1.visible) begin
            pix_next = '0;
        end else if (s1.hit && (spr_data != KEY)) begin
            pix_next = spr_data;
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            pix   <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            pix   <= pix_next;
            hsync <= s1.hsync;
            vsync <= s1.vsync;
        end
    end

    assign {r, g, b} = pix;
endmodule

// File: tb/tb_vga_pixel_render.sv
// Scoreboard bench for vga_pixel_render: expected pixels are queued at drive time and popped two cycles later.
module tb_vga_pixel_render;
    logic        vga_clk = 1'b0;
    logic        clrn;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        hsync_in;
    logic        vsync_in;
    logic [9:0]  obj_x;
    logic [9:0]  obj_y;
    logic        obj_en;
    logic [16:0] bg_addr;
    logic [11:0] bg_data;
    logic [9:0]  spr_addr;
    logic [11:0] spr_data;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        int          c;
        int          rw;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_lx = 0;
    int          m_ly = 0;
    logic        m_len = 1'b0;
    logic [11:0] spr_override = 12'h123;

    vga_pixel_render dut (
        .vga_clk     (vga_clk),
        .clrn        (clrn),
        .col         (col),
        .row         (row),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_en      (obj_en),
        .bg_addr     (bg_addr),
        .bg_data     (bg_data),
        .spr_addr    (spr_addr),
        .spr_data    (spr_data),
        .r           (r),
        .g           (g),
        .b           (b),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #20 vga_clk = ~vga_clk;

    function automatic logic [11:0] bg_rom(input logic [16:0] a);
        if (a == 17'd322) return 12'hABC;
        return a[11:0] ^ {a[16:12], 7'h2A};
    endfunction

    function automatic logic [11:0] spr_rom(input logic [9:0] a);
        if (a == 10'd67) return spr_override;
        if (a[3:0] == 4'hF) return 12'hF0F;
        return 12'(256 + 3 * int'(a));
    endfunction

    // Synchronous ROM models: data valid one cycle after the address.
    always @(posedge vga_clk) begin
        bg_data  <= bg_rom(bg_addr);
        spr_data <= spr_rom(spr_addr);
    end

    task automatic drive_pixel(input int c, input int rw, input logic hs, input logic vs);
        exp_t        e;
        exp_t        o;
        int          dx;
        int          dy;
        int          sa;
        int          bga;
        logic        vis;
        logic        hit;
        logic        trig;
        logic [11:0] sv;
        logic [11:0] bv;
        col      = 10'(c);
        row      = 10'(rw);
        hsync_in = hs;
        vsync_in = vs;
        vis  = (c < 640) && (rw < 480);
        dx   = c - m_lx;
        dy   = rw - m_ly;
        hit  = m_len && vis && (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
        sa   = hit ? dy * 32 + dx : 0;
        bga  = (rw / 2) * 320 + c / 2;
        sv   = spr_rom(10'(sa));
        bv   = bg_rom(17'(bga));
        e.rgb = !vis ? 12'h000 : ((hit && sv != 12'hF0F) ? sv : bv);
        e.hs  = hs;
        e.vs  = vs;
        e.c   = c;
        e.rw  = rw;
        exp_q.push_back(e);
        trig = (c == 0) && (rw == 480);
        @(posedge vga_clk);
        #1;
        if (trig) begin
            m_lx  = int'(obj_x);
            m_ly  = int'(obj_y);
            m_len = obj_en;
        end
        n_checks++;
        if (frame_start !== trig) begin
            n_errors++;
            $display("[TB] FAIL frame_start after col=%0d row=%0d: got %b, expected %b", c, rw, frame_start, trig);
        end
        if (exp_q.size() >= 2) begin
            o = exp_q.pop_front();
            n_checks++;
            if ({r, g, b} !== o.rgb) begin
                n_errors++;
                $display("[TB] FAIL rgb col=%0d row=%0d: got %h, expected %h", o.c, o.rw, {r, g, b}, o.rgb);
            end
            n_checks++;
            if (hsync !== o.hs) begin
                n_errors++;
                $display("[TB] FAIL hsync col=%0d row=%0d: got %b, expected %b", o.c, o.rw, hsync, o.hs);
            end
            n_checks++;
            if (vsync !== o.vs) begin
                n_errors++;
                $display("[TB] FAIL vsync col=%0d row=%0d: got %b, expected %b", o.c, o.rw, vsync, o.vs);
            end
        end
    endtask

    task automatic drive_vga(input int c, input int rw);
        drive_pixel(c, rw, !((c >= 656) && (c < 752)), !((rw >= 490) && (rw < 492)));
    endtask

    task automatic test_reset;
        clrn     = 1'b1;
        col      = 10'd200;
        row      = 10'd100;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        obj_x    = 10'd0;
        obj_y    = 10'd0;
        obj_en   = 1'b0;
        #2 clrn = 1'b0;
        #1;
        n_checks++;
        if ({r, g, b} !== 12'h000) begin
            n_errors++;
            $display("[TB] FAIL reset_rgb: got %h, expected 000", {r, g, b});
        end
        n_checks++;
        if ({hsync, vsync, frame_start} !== 3'b110) begin
            n_errors++;
            $display("[TB] FAIL reset_sync: got %b, expected 110", {hsync, vsync, frame_start});
        end
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1 clrn = 1'b1;
    endtask

    task automatic test_background;
        obj_en = 1'b0;
        col = 10'd5;
        row = 10'd3;
        #1;
        n_checks++;
        if (bg_addr !== 17'd322) begin
            n_errors++;
            $display("[TB] FAIL bg_addr: got %0d, expected 322", bg_addr);
        end
        for (int c = 5; c < 12; c++) drive_vga(c, 3);
    endtask

    task automatic test_latch_timing;
        obj_x  = 10'd100;
        obj_y  = 10'd50;
        obj_en = 1'b1;
        for (int c = 96; c < 110; c++) drive_vga(c, 200);
        for (int rw = 50; rw < 54; rw++)
            for (int c = 96; c < 140; c++) drive_vga(c, rw);
        drive_vga(0, 480);
        obj_x  = 10'd300;
        obj_en = 1'b0;
        drive_vga(1, 480);
        drive_vga(2, 480);
        for (int rw = 50; rw < 54; rw++)
            for (int c = 96; c < 140; c++) drive_vga(c, rw);
    endtask

    task automatic test_sprite_hit;
        spr_override = 12'h123;
        col = 10'd103;
        row = 10'd52;
        #1;
        n_checks++;
        if (spr_addr !== 10'd67) begin
            n_errors++;
            $display("[TB] FAIL spr_addr_hit: got %0d, expected 67", spr_addr);
        end
        drive_vga(103, 52);
        drive_vga(104, 52);
        drive_vga(105, 52);
        spr_override = 12'hF0F;
        drive_vga(103, 52);
        drive_vga(104, 52);
        drive_vga(105, 52);
        spr_override = 12'h123;
    endtask

    task automatic test_clip;
        obj_x  = 10'd620;
        obj_y  = 10'd0;
        obj_en = 1'b1;
        drive_vga(0, 480);
        for (int c = 610; c < 800; c++) begin
            col = 10'(c);
            row = 10'd0;
            #1;
            if (c == 639) begin
                n_checks++;
                if (spr_addr !== 10'd19) begin
                    n_errors++;
                    $display("[TB] FAIL clip_addr_639: got %0d, expected 19", spr_addr);
                end
            end
            if (c == 640) begin
                n_checks++;
                if (spr_addr !== 10'd0) begin
                    n_errors++;
                    $display("[TB] FAIL clip_addr_640: got %0d, expected 0", spr_addr);
                end
            end
            drive_vga(c, 0);
        end
        for (int c = 0; c < 12; c++) drive_vga(c, 1);
    endtask

    task automatic test_sync_sweep;
        int rows[6] = '{479, 480, 489, 490, 491, 492};
        for (int i = 0; i < 6; i++)
            for (int c = 0; c < 800; c++) drive_vga(c, rows[i]);
    endtask

    task automatic test_reset_mid;
        drive_pixel(200, 100, 1'b0, 1'b0);
        drive_pixel(201, 100, 1'b0, 1'b0);
        drive_pixel(202, 100, 1'b0, 1'b0);
        #5 clrn = 1'b0;
        #1;
        n_checks++;
        if ({r, g, b} !== 12'h000) begin
            n_errors++;
            $display("[TB] FAIL midreset_rgb: got %h, expected 000", {r, g, b});
        end
        n_checks++;
        if ({hsync, vsync, frame_start} !== 3'b110) begin
            n_errors++;
            $display("[TB] FAIL midreset_sync: got %b, expected 110", {hsync, vsync, frame_start});
        end
        exp_q.delete();
        m_lx  = 0;
        m_ly  = 0;
        m_len = 1'b0;
        @(posedge vga_clk);
        #1 clrn = 1'b1;
        for (int c = 640; c < 780; c++) drive_vga(c, 100);
        for (int c = 0; c < 40; c++) drive_vga(c, 10);
    endtask

    task automatic test_back_to_back;
        int ox;
        int oy;
        int c;
        int rw;
        ox     = int'($urandom_range(0, 639));
        oy     = int'($urandom_range(0, 479));
        obj_x  = 10'(ox);
        obj_y  = 10'(oy);
        obj_en = 1'b1;
        drive_vga(0, 480);
        for (int i = 0; i < 400; i++) begin
            c  = ox + int'($urandom_range(0, 40)) - 4;
            rw = oy + int'($urandom_range(0, 40)) - 4;
            if (c < 0) c = 0;
            if (c > 799) c = 799;
            if (rw < 0) rw = 0;
            if (rw > 524) rw = 524;
            drive_vga(c, rw);
        end
    endtask

    initial begin
        test_reset;
        test_background;
        test_latch_timing;
        test_sprite_hit;
        test_clip;
        test_sync_sweep;
        test_reset_mid;
        test_back_to_back;
        drive_vga(700, 500);
        drive_vga(701, 500);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vga_pixel_render.md
Name: vga_pixel_render

Overview:
- Pixel-colour stage directly downstream of vga_sync. It consumes the raw col/row counters and hsync/vsync.
- Composites a 2x-scaled background image with one 32x32 player sprite (colour-keyed). Both images come from external synchronous ROMs.
- Drives 4:4:4 RGB plus delay-matched sync signals to the VGA connector.
- Latches the sprite position once per frame, in vertical blank, so the sprite never tears.

Parameters:
- H_VIS, 640, visible columns.
- V_VIS, 480, visible rows.
- SPR_W, 32, sprite width (power of 2).
- SPR_H, 32, sprite height (power of 2).
- BG_W, 320, background ROM line width (H_VIS/2).
- KEY, 12'hF0F, transparent sprite colour.

Ports:
- vga_clk  in  1  pixel clock (25 MHz)
- clrn  in  1  asynchronous active-low reset
- col  in  10  horizontal counter from vga_sync (0..799; visible when < H_VIS)
- row  in  10  vertical counter from vga_sync (0..524; visible when < V_VIS)
- hsync_in  in  1  hsync from vga_sync (active-low)
- vsync_in  in  1  vsync from vga_sync (active-low)
- obj_x  in  10  sprite top-left column requested by game logic
- obj_y  in  10  sprite top-left row requested by game logic
- obj_en  in  1  sprite enable requested by game logic
- bg_addr  out  17  background ROM address (combinational)
- bg_data  in  12  background ROM data, valid 1 cycle after the address
- spr_addr  out  10  sprite ROM address (combinational)
- spr_data  in  12  sprite ROM data, valid 1 cycle after the address
- r, g, b  out  4 each  pixel colour
- hsync  out  1  hsync_in delayed to align with r/g/b
- vsync  out  1  vsync_in delayed to align with r/g/b
- frame_start  out  1  one-cycle pulse when a new position is latched

Behaviour:
- Clock and reset: single clock vga_clk. Asynchronous active-low reset clrn.
- Reset values:
  - r/g/b = 0.
  - hsync = vsync = 1.
  - frame_start = 0.
  - Latched lx/ly = 0, len = 0.
  - All pipeline valid/hit flags = 0.
- Reset mid-frame: output goes black immediately and syncs go inactive immediately.
- Recovery after reset: correct alignment resumes 2 cycles after clrn deasserts. No partial-frame sprite is drawn until the next latch.
- Pipeline (cycle N = cycle in which col/row are presented):
  - Stage 0 (cycle N, combinational):
    - bg_addr = (row>>1)*BG_W + (col>>1), computed in 17 bits.
    - dx = col - lx and dy = row - ly, computed in 11 bits signed.
    - hit = len & dx in [0,SPR_W) & dy in [0,SPR_H) & visible.
    - spr_addr = hit ? dy[4:0]*SPR_W + dx[4:0] : 0.
    - visible = (col < H_VIS) & (row < V_VIS).
  - Edge ending cycle N: ROMs register data. Stage-1 registers capture visible, hit, hsync_in and vsync_in.
  - Edge ending cycle N+1: output registers load.
    - If !visible1: rgb = 0.
    - Else if hit1 & spr_data != KEY: rgb = spr_data.
    - Else: rgb = bg_data.
    - hsync/vsync load the stage-1 copies.
- Latency: exactly 2 cycles for rgb, hsync and vsync. They are always mutually aligned.
- Position latch:
  - Trigger: cycle where col == 0 and row == V_VIS (first blank line).
  - On that cycle's edge, load lx <= obj_x, ly <= obj_y, len <= obj_en.
  - frame_start = 1 for the following cycle only.
- obj_* changes at any other time have no effect on the current frame.
- Clipping:
  - The sprite overlapping the right or bottom edge is clipped by the visible term.
  - There is no wrap into the next line or frame.
  - Positions >= H_VIS/V_VIS yield no hit.
- Arithmetic: all compares are unsigned after a sign check on the 11-bit difference. Negative dx/dy means no hit.

Decomposition:
- Shared package vga_pkg holds:
  - H_VIS, V_VIS, H_TOTAL=800, V_TOTAL=525.
  - The RGB444 width.
  - KEY.
- One sub-module, vga_sprite_hit: combinational window compare plus spr_addr generation. It takes col, row, lx, ly, len. It is reused later for extra objects.

Test Plan:
- Reset: clrn=0 mid-frame -> r/g/b=0, hsync=vsync=1, frame_start=0 asynchronously. After release, hsync follows hsync_in with 2-cycle lag.
- Background: obj_en=0, col=5, row=3 -> bg_addr=322 same cycle. ROM model returns 12'hABC -> r=A, g=B, b=C two cycles after the col/row cycle.
- Latch timing: obj_x=100, obj_y=50, obj_en=1 applied at row=200 -> no sprite that frame. At row=480, col=0 the latch loads. frame_start=1 for exactly one cycle. The next frame shows the sprite.
- Sprite hit with lx=100, ly=50 and col=103, row=52 -> spr_addr=67:
  - spr_data=12'h123 -> rgb=123.
  - spr_data=12'hF0F -> rgb equals bg_data.
- Clip: lx=620, ly=0:
  - col=639 -> hit with spr_addr low bits 19.
  - col=640..799 -> rgb=0.
  - col=0..11 of the next row -> background only, no wrap.
- Blanking/sync alignment: sweep a full 800x525 frame with the vga_sync model. rgb is 0 whenever col>=640 or row>=480 (2-cycle lag). hsync/vsync edges occur exactly 2 cycles after the input edges.
